wash_sequencer: RTL and testbench



---
 rtl/wash_sequencer.sv | 151 +++++++++++++++
 tb/tb_wash_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - wash program sequencer: stage stepping, per-second countdown, digit codes
// Optional fault hold (ERROR state) is built only when WASH_ERR_EN is defined.
module wash_sequencer #(
  parameter int WATER_S  = 5,
  parameter int WASH_S   = 20,
  parameter int RINSE_S  = 10,
  parameter int SPIN_S   = 8,
  parameter int FINISH_S = 6
) (
  input  logic       cp,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       err,
  input  logic [7:0] stage_en,
  output logic [2:0] state,
  output logic [2:0] shinning,
  output logic [7:0] pending,
  output logic [5:0] inLeft,
  output logic [5:0] inMiddle,
  output logic [5:0] inRight
);

  typedef enum logic [2:0] {
    SET_ST    = 3'd2,
    RUN_ST    = 3'd3,
    ERROR_ST  = 3'd4,
    PAUSE_ST  = 3'd5,
    FINISH_ST = 3'd6
  } stateT;

  stateT       curState;
  logic [6:0]  timer;
  logic [17:0] digits;
  logic        errActive;
  logic [7:0]  remaining;
  logic [2:0]  nextIdx;
  logic [2:0]  firstEn;

`ifdef WASH_ERR_EN
  assign errActive = err;
`else
  assign errActive = 1'b0 & err;
`endif

  function automatic logic [2:0] firstIdx(input logic [7:0] m);
    firstIdx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[7-i]) firstIdx = 3'(i);
    end
  endfunction

  function automatic logic [6:0] stageDur(input logic [2:0] idx);
    case (idx)
      3'd1:       stageDur = 7'(WASH_S);
      3'd5:       stageDur = 7'(RINSE_S);
      3'd3, 3'd7: stageDur = 7'(SPIN_S);
      default:    stageDur = 7'(WATER_S);
    endcase
  endfunction

  function automatic logic [5:0] popCount(input logic [7:0] m);
    popCount = 6'd0;
    for (int i = 0; i < 8; i++) popCount = popCount + {5'd0, m[i]};
  endfunction

  // {left, middle, right}; left is 0 for the finish window
  function automatic logic [17:0] showDigits(input logic [5:0] left, input logic [6:0] t);
    showDigits = {left, 6'(t / 7'd10), 6'(t % 7'd10)};
  endfunction

  assign remaining = pending & ~(8'h80 >> shinning);
  assign nextIdx   = firstIdx(remaining);
  assign firstEn   = firstIdx(stage_en);

  always_ff @(posedge cp) begin
    if (!rst_n) begin
      curState <= SET_ST;
      shinning <= 3'd0;
      pending  <= 8'd0;
      timer    <= 7'd0;
      digits   <= 18'd0;
    end else begin
      case (curState)
        SET_ST: begin
          if (start && stage_en != 8'd0) begin
            curState <= RUN_ST;
            pending  <= stage_en;
            shinning <= firstEn;
            timer    <= stageDur(firstEn);
            digits   <= showDigits(6'(firstEn) + 6'd1, stageDur(firstEn));
          end else begin
            digits <= {12'd0, popCount(stage_en)};
          end
        end
        RUN_ST: begin
          if (errActive) begin
            curState <= ERROR_ST;
          end else if (pause) begin
            curState <= PAUSE_ST;
          end else if (sec_tick) begin
            if (timer > 7'd1) begin
              timer  <= timer - 7'd1;
              digits <= showDigits(6'(shinning) + 6'd1, timer - 7'd1);
            end else begin
              pending <= remaining;
              if (remaining != 8'd0) begin
                shinning <= nextIdx;
                timer    <= stageDur(nextIdx);
                digits   <= showDigits(6'(nextIdx) + 6'd1, stageDur(nextIdx));
              end else begin
                curState <= FINISH_ST;
                timer    <= 7'(FINISH_S);
                digits   <= showDigits(6'd0, 7'(FINISH_S));
              end
            end
          end
        end
        PAUSE_ST: begin
          if (errActive) curState <= ERROR_ST;
          else if (start) curState <= RUN_ST;
        end
        ERROR_ST: begin
          if (start && !errActive) curState <= RUN_ST;
        end
        FINISH_ST: begin
          if (sec_tick) begin
            if (timer > 7'd1) begin
              timer  <= timer - 7'd1;
              digits <= showDigits(6'd0, timer - 7'd1);
            end else begin
              curState <= SET_ST;
              pending  <= 8'd0;
              shinning <= 3'd0;
              timer    <= 7'd0;
              digits   <= {12'd0, popCount(stage_en)};
            end
          end
        end
        default: curState <= SET_ST;
      endcase
    end
  end

  assign state    = curState;
  assign inLeft   = digits[17:12];
  assign inMiddle = digits[11:6];
  assign inRight  = digits[5:0];

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - directed bench for wash_sequencer with hand-computed expectations
// Define WASH_ERR_EN for both bench and RTL to exercise the fault hold.
module tb_wash_sequencer;

  logic       cp = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       err = 1'b0;
  logic [7:0] stage_en = 8'd0;
  logic [2:0] state;
  logic [2:0] shinning;
  logic [7:0] pending;
  logic [5:0] inLeft;
  logic [5:0] inMiddle;
  logic [5:0] inRight;

  int passCount = 0;
  int totalCount = 0;

  wash_sequencer dut (
    .cp(cp), .rst_n(rst_n), .sec_tick(sec_tick), .start(start), .pause(pause),
    .err(err), .stage_en(stage_en), .state(state), .shinning(shinning),
    .pending(pending), .inLeft(inLeft), .inMiddle(inMiddle), .inRight(inRight)
  );

  always #5 cp = ~cp;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    if (obs === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkDigits(input string tag, input int l, input int m, input int r);
    checkEq({tag, ".left"}, 32'(inLeft), 32'(l));
    checkEq({tag, ".middle"}, 32'(inMiddle), 32'(m));
    checkEq({tag, ".right"}, 32'(inRight), 32'(r));
  endtask

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1;
      step();
      sec_tick = 1'b0;
      step();
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    step();
    step();
    checkEq("rst.state", 32'(state), 32'd2);
    checkEq("rst.shinning", 32'(shinning), 32'd0);
    checkEq("rst.pending", 32'(pending), 32'd0);
    checkDigits("rst", 0, 0, 0);
    rst_n = 1'b1;

    pulseStart();
    checkEq("empty_start.state", 32'(state), 32'd2);

    // single drain stage, then the finish window
    stage_en = 8'h80;
    step();
    checkDigits("set_pop", 0, 0, 1);
    pulseStart();
    checkEq("t1.state", 32'(state), 32'd3);
    checkEq("t1.shinning", 32'(shinning), 32'd0);
    checkEq("t1.pending", 32'(pending), 32'h80);
    checkDigits("t1.start", 1, 0, 5);
    ticks(4);
    checkDigits("t1.tick4", 1, 0, 1);
    ticks(1);
    checkEq("t1.fin_state", 32'(state), 32'd6);
    checkEq("t1.fin_pending", 32'(pending), 32'd0);
    checkDigits("t1.fin", 0, 0, 6);
    ticks(5);
    checkEq("t1.fin5_state", 32'(state), 32'd6);
    checkDigits("t1.fin5", 0, 0, 1);
    ticks(1);
    checkEq("t1.back_set", 32'(state), 32'd2);
    checkDigits("t1.set", 0, 0, 1);

    // stage advance 0 -> 1
    stage_en = 8'hC0;
    pulseStart();
    ticks(4);
    checkEq("t2.pending_pre", 32'(pending), 32'hC0);
    checkDigits("t2.pre", 1, 0, 1);
    ticks(1);
    checkEq("t2.shinning", 32'(shinning), 32'd1);
    checkEq("t2.pending", 32'(pending), 32'h40);
    checkDigits("t2.adv", 2, 2, 0);

    // pause at 15, ticks ignored, resume
    ticks(5);
    checkDigits("t3.at15", 2, 1, 5);
    pause = 1'b1;
    step();
    pause = 1'b0;
    checkEq("t3.paused", 32'(state), 32'd5);
    ticks(3);
    checkEq("t3.still_paused", 32'(state), 32'd5);
    checkDigits("t3.hold", 2, 1, 5);
    pulseStart();
    checkEq("t3.resumed", 32'(state), 32'd3);
    ticks(1);
    checkDigits("t3.resume_tick", 2, 1, 4);

    // pause wins over a coincident tick at 7
    ticks(7);
    checkDigits("t4.at7", 2, 0, 7);
    pause = 1'b1;
    sec_tick = 1'b1;
    step();
    pause = 1'b0;
    sec_tick = 1'b0;
    checkEq("t4.state", 32'(state), 32'd5);
    checkDigits("t4.timer", 2, 0, 7);
    pulseStart();
    checkEq("t4.resume", 32'(state), 32'd3);
    start = 1'b1;
    pause = 1'b1;
    step();
    start = 1'b0;
    pause = 1'b0;
    checkEq("t4.pause_over_start", 32'(state), 32'd5);
    pulseStart();

`ifdef WASH_ERR_EN
    err = 1'b1;
    step();
    checkEq("t5.error", 32'(state), 32'd4);
    ticks(2);
    pulseStart();
    checkEq("t5.err_hold", 32'(state), 32'd4);
    err = 1'b0;
    step();
    pulseStart();
    checkEq("t5.recover", 32'(state), 32'd3);
    checkDigits("t5.timer", 2, 0, 7);
`else
    err = 1'b1;
    step();
    checkEq("t5.err_ignored", 32'(state), 32'd3);
    err = 1'b0;
`endif

    // finish, then reset mid-window
    ticks(7);
    checkEq("t6.fin", 32'(state), 32'd6);
    checkDigits("t6.fin", 0, 0, 6);
    ticks(2);
    pulseStart();
    checkEq("t6.fin_ignores_start", 32'(state), 32'd6);
    checkDigits("t6.fin2", 0, 0, 4);
    rst_n = 1'b0;
    step();
    checkEq("t6.rst_state", 32'(state), 32'd2);
    checkEq("t6.rst_shinning", 32'(shinning), 32'd0);
    checkEq("t6.rst_pending", 32'(pending), 32'd0);
    checkDigits("t6.rst", 0, 0, 0);
    rst_n = 1'b1;

    // sparse mask, late stage_en change has no effect
    stage_en = 8'h21;
    pulseStart();
    checkEq("t7.shinning", 32'(shinning), 32'd2);
    checkEq("t7.pending", 32'(pending), 32'h21);
    checkDigits("t7.start", 3, 0, 5);
    stage_en = 8'hFF;
    ticks(5);
    checkEq("t7.adv_shinning", 32'(shinning), 32'd7);
    checkEq("t7.adv_pending", 32'(pending), 32'h01);
    checkDigits("t7.adv", 8, 0, 8);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
